// File: rtl/add_sub_unit.sv
// Registered N-bit two's-complement adder/subtractor with carry, overflow, zero and negative flags.
// One result per cycle with one cycle of latency; out and flags hold their value between valid results.
`timescale 1ns/1ps

module add_sub_unit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         sub,
    input  logic         in_valid,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         carry,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic [N-1:0] result;
    logic         result_carry;
    logic         result_overflow;

    // Subtraction is A + ~B + 1, so carry-out doubles as "no borrow".
    always_comb begin
        b_eff           = in_b ^ {N{sub}};
        sum             = {1'b0, in_a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
        result          = sum[N-1:0];
        result_carry    = sum[N];
        result_overflow = (in_a[N-1] == b_eff[N-1]) && (result[N-1] != in_a[N-1]);
    end

    // Flags are registered together with out so they always describe the same operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out      <= result;
                carry    <= result_carry;
                overflow <= result_overflow;
                zero     <= (result == '0);
                negative <= result[N-1];
            end
        end
    end

endmodule

// File: tb/tb_add_sub_unit.sv
// Scoreboard bench for add_sub_unit: N=8 and N=16 instances checked against an integer-arithmetic model.
// Expected results are queued when driven and popped by per-instance monitors on the falling edge.
`timescale 1ns/1ps

module tb_add_sub_unit;

    typedef struct {
        logic [15:0] out;
        logic        carry;
        logic        overflow;
        logic        zero;
        logic        negative;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a8, b8, out8;
    logic        sub8, valid8, out_valid8, carry8, overflow8, zero8, negative8;
    logic [15:0] a16, b16, out16;
    logic        sub16, valid16, out_valid16, carry16, overflow16, zero16, negative16;

    exp_t q8[$];
    exp_t q16[$];
    exp_t held8, held16;
    exp_t zero_exp;
    bit   in_reset;
    int   compared;
    int   mismatched;

    add_sub_unit #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_a(a8), .in_b(b8), .sub(sub8), .in_valid(valid8),
        .out(out8), .out_valid(out_valid8), .carry(carry8), .overflow(overflow8),
        .zero(zero8), .negative(negative8)
    );

    add_sub_unit #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_a(a16), .in_b(b16), .sub(sub16), .in_valid(valid16),
        .out(out16), .out_valid(out_valid16), .carry(carry16), .overflow(overflow16),
        .zero(zero16), .negative(negative16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input longint a, input longint b, input bit s);
        exp_t   e;
        longint m   = longint'(1) <<< w;
        longint r   = s ? (a - b) : (a + b);
        longint res = ((r % m) + m) % m;
        longint sa  = (a >= m / 2) ? a - m : a;
        longint sb  = (b >= m / 2) ? b - m : b;
        longint sr  = s ? (sa - sb) : (sa + sb);
        e.out      = 16'(res);
        e.carry    = s ? (a >= b) : (r >= m);
        e.overflow = (sr > m / 2 - 1) || (sr < -(m / 2));
        e.zero     = (res == 0);
        e.negative = (res >= m / 2);
        return e;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v_act, input logic v_exp,
                               input logic [15:0] o, input logic c, input logic ov,
                               input logic z, input logic n, input exp_t e);
        cmp({tag, ".out_valid"}, {15'd0, v_act}, {15'd0, v_exp});
        cmp({tag, ".out"}, o, e.out);
        cmp({tag, ".carry"}, {15'd0, c}, {15'd0, e.carry});
        cmp({tag, ".overflow"}, {15'd0, ov}, {15'd0, e.overflow});
        cmp({tag, ".zero"}, {15'd0, z}, {15'd0, e.zero});
        cmp({tag, ".negative"}, {15'd0, n}, {15'd0, e.negative});
    endtask

    // Monitors: a queued entry is due exactly one edge after it was driven.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (q8.size() > 0) begin
                held8 = q8.pop_front();
                checkOutput("n8", out_valid8, 1'b1, {8'd0, out8}, carry8, overflow8, zero8, negative8, held8);
            end else begin
                checkOutput("n8_idle", out_valid8, 1'b0, {8'd0, out8}, carry8, overflow8, zero8, negative8, held8);
            end
        end
    end

    always @(negedge clk) begin
        if (!in_reset) begin
            if (q16.size() > 0) begin
                held16 = q16.pop_front();
                checkOutput("n16", out_valid16, 1'b1, out16, carry16, overflow16, zero16, negative16, held16);
            end else begin
                checkOutput("n16_idle", out_valid16, 1'b0, out16, carry16, overflow16, zero16, negative16, held16);
            end
        end
    end

    task automatic applyStimulus(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input bit s, input bit v);
        @(negedge clk);
        #1;
        valid8  = 1'b0;
        valid16 = 1'b0;
        sub8    = ~s;
        sub16   = ~s;
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; sub8 = s; valid8 = v;
            if (v) q8.push_back(model(8, longint'(a[7:0]), longint'(b[7:0]), s));
        end else begin
            a16 = a; b16 = b; sub16 = s; valid16 = v;
            if (v) q16.push_back(model(16, longint'(a), longint'(b), s));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_n8"}, out_valid8, 1'b0, {8'd0, out8}, carry8, overflow8, zero8, negative8, zero_exp);
        checkOutput({tag, "_n16"}, out_valid16, 1'b0, out16, carry16, overflow16, zero16, negative16, zero_exp);
    endtask

    // Asserts reset mid-cycle, checks the immediate clear, then releases on a falling edge.
    task automatic midCycleReset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        q8.delete();
        q16.delete();
        held8    = zero_exp;
        held16   = zero_exp;
        #1;
        checkResetOutputs("async_reset");
        @(negedge clk);
        #1;
        valid8   = 1'b0;
        valid16  = 1'b0;
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        zero_exp   = '{out: 16'd0, carry: 1'b0, overflow: 1'b0, zero: 1'b0, negative: 1'b0};
        held8      = zero_exp;
        held16     = zero_exp;
        in_reset   = 1'b1;
        rst_n      = 1'b0;
        {a8, b8, sub8, valid8}     = '0;
        {a16, b16, sub16, valid16} = '0;

        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset_state");
        rst_n    = 1'b1;
        in_reset = 1'b0;

        applyStimulus(8, 14, 3, 1, 1);
        applyStimulus(8, 20, 20, 1, 1);
        applyStimulus(8, 14, 3, 1, 1);
        applyStimulus(8, 100, 2, 1, 1);
        applyStimulus(8, 5, 3, 1, 1);
        applyStimulus(8, 1, 1, 0, 1);
        applyStimulus(8, 100, 3, 0, 1);
        applyStimulus(8, 200, 100, 0, 1);
        applyStimulus(8, 100, 100, 0, 1);
        applyStimulus(8, 3, 5, 1, 1);
        applyStimulus(8, 128, 1, 1, 1);
        applyStimulus(8, 0, 0, 1, 1);
        applyStimulus(8, 14, 3, 1, 1);
        applyStimulus(8, 99, 42, 0, 0);
        applyStimulus(8, 10, 3, 1, 1);
        applyStimulus(8, 0, 0, 0, 0);
        applyStimulus(16, 40000, 30000, 0, 1);
        applyStimulus(16, 1000, 1000, 1, 1);
        applyStimulus(16, 16'h8000, 1, 1, 1);

        applyStimulus(8, 1, 1, 0, 1);
        midCycleReset();
        applyStimulus(8, 14, 3, 1, 1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(8, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(16, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        applyStimulus(8, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        cmp("drain_q8", 16'(q8.size()), 16'd0);
        cmp("drain_q16", 16'(q16.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/add_sub_unit.md
Name: add_sub_unit

Overview:
Registered N-bit two's-complement adder/subtractor with status flags, used as the arithmetic datapath element of the processor's ALU stage. Each cycle it accepts two operands and an operation select, and one clock later presents the result, a result-valid strobe and the carry/overflow/zero/negative flags.

Parameters:
N, 8, operand and result width in bits (N >= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_a  input  N  operand A
in_b  input  N  operand B
sub  input  1  operation select: 0 = A + B, 1 = A - B
in_valid  input  1  operands and sub are valid this cycle
out  output  N  registered result
out_valid  output  1  out and flags hold a new result this cycle
carry  output  1  add: unsigned carry-out; sub: 1 = no borrow (A >= B unsigned)
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0
negative  output  1  result MSB

Behaviour:
- Reset: when rst_n is low, out, out_valid, carry, overflow, zero and negative clear to 0 immediately, independent of clk. They stay 0 while rst_n is low.
- Reset deasserted mid-operation: any operation in flight is discarded. The first result appears one cycle after the first in_valid sampled with rst_n high.
- Arithmetic:
  - sum = in_a + (in_b XOR {N{sub}}) + sub, computed at N+1 bits.
  - out = sum[N-1:0], i.e. result modulo 2^N (wrap-around, no saturation).
  - carry = sum[N].
  - overflow = (a_msb == b_eff_msb) && (out_msb != a_msb), where b_eff is in_b XOR {N{sub}}.
  - zero = (out == 0); negative = out[N-1].
- Latency: exactly 1 cycle. On a rising clk edge with in_valid=1, the result and flags register and out_valid=1 for that following cycle.
- Edge with in_valid=0: out_valid goes 0. out and flags hold their previous values; they are not cleared.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure: results are not stored beyond one cycle and must be consumed when out_valid=1.
- sub changing while in_valid=0 has no effect.
- Inputs must be stable around the clock edge. There is no internal input buffering.
- Flags are always computed from the operation latched alongside out. They are never stale relative to out.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with outputs nonzero -> out=0, out_valid=0 and all flags 0 immediately. Release rst_n, apply sub=1, A=14, B=3 -> next cycle out=11, out_valid=1.
- Subtract sequence (N=8), one per cycle with in_valid=1:
  - 20-20 -> out=0, zero=1, carry=1.
  - 14-3 -> out=11.
  - 100-2 -> out=98.
  - 5-3 -> out=2, carry=1, overflow=0.
  - Each result arrives 1 cycle after its input, back-to-back.
- Add sequence:
  - 1+1 -> out=2.
  - 100+3 -> out=103, carry=0, overflow=0.
  - 200+100 -> out=44, carry=1 (wrap).
  - 100+100 -> out=200, overflow=1, negative=1.
- Borrow and signed subtract:
  - 3-5 -> out=254, carry=0, negative=1.
  - 128-1 -> out=127, overflow=1.
  - 0-0 -> out=0, zero=1, carry=1.
- Valid gating: in_valid pattern 1,0,1 with results 11 then 7 -> out_valid pattern 1,0,1. out holds 11 during the gap cycle.
- Parameter check N=16: 40000+30000 -> out=4464, carry=1. 1000-1000 -> zero=1.
